// File: rtl/ntt_sched_if.sv
// ntt_sched_if: butterfly command issue and write-back completion handshake
interface ntt_sched_if #(parameter int LOG_N = 4);
  logic             bf_valid;
  logic             bf_ready;
  logic [LOG_N-1:0] bf_addr_a;
  logic [LOG_N-1:0] bf_addr_b;
  logic [LOG_N-1:0] bf_tw_idx;
  logic [2:0]       bf_stage;
  logic             wb_done;
  modport master (output bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage, input bf_ready, wb_done);
  modport slave  (input bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage, output bf_ready, wb_done);
endinterface

// File: rtl/ntt_sched.sv
// ntt_sched: radix-2 DIT NTT butterfly sequencer with write-back credits and stage barrier; NTT_SCHED_INVERSE_EN enables inverse twiddle indices
module ntt_sched #(
  parameter int LOG_N   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        inverse,
  output logic        busy,
  output logic        done,
  output logic        err,
  ntt_sched_if.master bus
);
  localparam int HALF = 1 << (LOG_N - 1);
  localparam int CW   = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t           state, state_n;
  logic [2:0]       stage, stage_n;
  logic [LOG_N-1:0] b, b_n, m, j, g, a_n, tw_n, tw_o;
  logic [CW-1:0]    cnt, cnt_n;
  logic             acc, err_n, valid_n;
  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = state == DONE;
  // Next-state, credit count and the command that will be presented next cycle
  always_comb begin
    acc     = bus.bf_valid & bus.bf_ready;
    cnt_n   = (acc & ~bus.wb_done) ? cnt + CW'(1) : (~acc & bus.wb_done & (cnt != '0)) ? cnt - CW'(1) : cnt;
    err_n   = err | (bus.wb_done & ~acc & (cnt == '0));
    state_n = state;
    stage_n = stage;
    b_n     = b;
    case (state)
      IDLE: if (start) begin
        state_n = ISSUE;
        stage_n = '0;
        b_n     = '0;
        cnt_n   = '0;
        err_n   = 1'b0;
      end
      ISSUE: if (acc) begin
        b_n     = b + LOG_N'(1);
        state_n = (b == LOG_N'(HALF - 1)) ? DRAIN : ISSUE;
      end
      DRAIN: if (cnt_n == '0) begin
        state_n = (stage == 3'(LOG_N - 1)) ? DONE : ISSUE;
        stage_n = (stage == 3'(LOG_N - 1)) ? stage : stage + 3'd1;
        b_n     = '0;
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == ISSUE) && (cnt_n < CW'(MAX_OUT));
    m       = LOG_N'(1) << stage_n;
    j       = b_n & (m - LOG_N'(1));
    g       = b_n >> stage_n;
    a_n     = (g << (stage_n + 3'd1)) | j;
    tw_n    = j << (3'(LOG_N - 1) - stage_n);
  end
`ifdef NTT_SCHED_INVERSE_EN
  logic inv_q, inv_n;
  assign inv_n = (state == IDLE && start) ? inverse : inv_q;
  assign tw_o  = inv_n ? -tw_n : tw_n;
  // Transform direction is captured with the accepted start
  always_ff @(posedge clk) inv_q <= rst ? 1'b0 : inv_n;
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign tw_o           = tw_n;
`endif
  // Control state plus registered command fields, which only move when a new command is due
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stage         <= '0;
      b             <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      bus.bf_valid  <= 1'b0;
      bus.bf_addr_a <= '0;
      bus.bf_addr_b <= '0;
      bus.bf_tw_idx <= '0;
      bus.bf_stage  <= '0;
    end else begin
      state        <= state_n;
      stage        <= stage_n;
      b            <= b_n;
      cnt          <= cnt_n;
      err          <= err_n;
      bus.bf_valid <= valid_n;
      if (state_n == ISSUE) begin
        bus.bf_addr_a <= a_n;
        bus.bf_addr_b <= a_n | m;
        bus.bf_tw_idx <= tw_o;
        bus.bf_stage  <= stage_n;
      end
    end
  end
endmodule

// File: tb/tb_ntt_sched.sv
// tb_ntt_sched: directed checks of command order, latency, credits, barrier, error flag, reset and twiddle direction
module tb_ntt_sched;
  logic clk = 1'b0;
  logic rst, start, inverse, busy, done, err;
  ntt_sched_if #(.LOG_N(4)) bus();
  ntt_sched #(.LOG_N(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic wb_en, wb_man;
  int wb_dly;
  logic [31:0] sr;
  int acc_n, stall_bad, wb_seen, wb_at_s1;
  logic s1_seen, pend, acc_now;
  logic [3:0] ra [64], rb [64], rt [64], pa, pb, pt;
  logic [2:0] rs [64];
  int ram [16];
  int t, x;
  int edge_n, busy_n, bad, ea, eb, et, es, gold;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int pw(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = (r * 8) % 97;
    return r;
  endfunction
  function automatic int br(input int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic inv);
    acc_n = 0; stall_bad = 0; wb_seen = 0; s1_seen = 1'b0; wb_at_s1 = -1;
    for (int i = 0; i < 16; i++) ram[i] = br(i) + 1;
    start = 1'b1; inverse = inv;
    tick;
    start = 1'b0; inverse = 1'b0;
  endtask
  task automatic run_to_done(input int budget);
    edge_n = -1;
    busy_n = int'(busy);
    for (int c = 1; c <= budget; c++) begin
      tick;
      if (done) begin
        edge_n = c + 1;
        break;
      end
      busy_n += int'(busy);
    end
  endtask
  task automatic check_seq(input string tag);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      es = k / 8;
      eb = (k % 8) / (1 << es) * 2 * (1 << es) + (k % 8) % (1 << es);
      ea = eb;
      eb = ea + (1 << es);
      et = ((k % 8) % (1 << es)) * (8 / (1 << es));
      if (ra[k] != 4'(ea) || rb[k] != 4'(eb) || rt[k] != 4'(et) || rs[k] != 3'(es)) bad++;
    end
    check(tag, bad, 0);
  endtask
  // Write-back model: wb_done follows an accept by wb_dly cycles, or a manual pulse
  always @(posedge clk) begin
    acc_now = bus.bf_valid && bus.bf_ready;
    #2;
    sr = {sr[30:0], acc_now};
    bus.wb_done = wb_man || (wb_en && sr[wb_dly-1]);
  end
  // Accept recorder, stall-stability monitor, barrier observer and butterfly datapath model
  always @(posedge clk) begin
    if (pend && bus.bf_valid && (bus.bf_addr_a != pa || bus.bf_addr_b != pb || bus.bf_tw_idx != pt)) stall_bad++;
    pend = bus.bf_valid && !bus.bf_ready;
    pa = bus.bf_addr_a; pb = bus.bf_addr_b; pt = bus.bf_tw_idx;
    if (bus.bf_valid && bus.bf_stage == 3'd1 && !s1_seen) begin
      s1_seen = 1'b1;
      wb_at_s1 = wb_seen;
    end
    if (bus.wb_done) wb_seen++;
    if (bus.bf_valid && bus.bf_ready) begin
      if (acc_n < 64) begin
        ra[acc_n] = bus.bf_addr_a; rb[acc_n] = bus.bf_addr_b;
        rt[acc_n] = bus.bf_tw_idx; rs[acc_n] = bus.bf_stage;
      end
      t = (pw(int'(bus.bf_tw_idx)) * ram[bus.bf_addr_b]) % 97;
      x = ram[bus.bf_addr_a];
      ram[bus.bf_addr_a] = (x + t) % 97;
      ram[bus.bf_addr_b] = (x - t + 97) % 97;
      acc_n++;
    end
  end
  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0;
    bus.bf_ready = 1'b0; wb_en = 1'b0; wb_man = 1'b0; wb_dly = 1; sr = '0;
    acc_n = 0; stall_bad = 0; wb_seen = 0; s1_seen = 1'b0; pend = 1'b0;
    repeat (2) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", bus.bf_valid, 0);
    check("rst_a", bus.bf_addr_a, 0);
    check("rst_b", bus.bf_addr_b, 0);
    check("rst_tw", bus.bf_tw_idx, 0);
    check("rst_stage", bus.bf_stage, 0);
    rst = 1'b0;
    tick;
    // forward run at full rate
    bus.bf_ready = 1'b1; wb_en = 1'b1; wb_dly = 1;
    do_start(1'b0);
    check("first_valid", bus.bf_valid, 1);
    check("first_a", bus.bf_addr_a, 0);
    check("first_b", bus.bf_addr_b, 1);
    check("first_tw", bus.bf_tw_idx, 0);
    check("first_busy", busy, 1);
    run_to_done(100);
    check("done_edge", edge_n, 37);
    check("busy_cycles", busy_n, 36);
    tick;
    check("done_pulse", done, 0);
    check("fwd_accepts", acc_n, 32);
    check("s0_b1_a", ra[1], 2);
    check("s0_b1_b", rb[1], 3);
    check("s0_b7_a", ra[7], 14);
    check("s0_b7_b", rb[7], 15);
    check("s0_b7_tw", rt[7], 0);
    check("s3_b7_a", ra[31], 7);
    check("s3_b7_b", rb[31], 15);
    check("s3_b7_tw", rt[31], 7);
    check("s3_b7_stage", rs[31], 3);
    check_seq("fwd_seq");
    check("fwd_err", err, 0);
    check("ram0", ram[0], 39);
    for (int k = 0; k < 16; k++) begin
      gold = 0;
      for (int n = 0; n < 16; n++) gold = (gold + (n + 1) * pw((n * k) % 16)) % 97;
      check($sformatf("ram%0d", k), ram[k], gold);
    end
    // random back-pressure
    repeat (3) tick;
    do_start(1'b0);
    for (int c = 0; c < 1000 && !done; c++) begin
      bus.bf_ready = 1'($urandom_range(0, 1));
      tick;
    end
    check("bp_done", done, 1);
    check("bp_accepts", acc_n, 32);
    check("bp_stable", stall_bad, 0);
    check_seq("bp_seq");
    // credit limit
    bus.bf_ready = 1'b1; wb_en = 1'b0;
    repeat (3) tick;
    do_start(1'b0);
    repeat (20) tick;
    check("credit_accepts", acc_n, 4);
    check("credit_valid", bus.bf_valid, 0);
    wb_man = 1'b1; tick; wb_man = 1'b0;
    repeat (5) tick;
    check("credit_one_more", acc_n, 5);
    check("credit_valid2", bus.bf_valid, 0);
    wb_man = 1'b1; tick; tick; wb_man = 1'b0;
    repeat (5) tick;
    check("credit_same_cycle", acc_n, 7);
    check("credit_err", err, 0);
    rst = 1'b1; tick; rst = 1'b0; tick;
    // stage barrier with slow write-back
    wb_en = 1'b1; wb_dly = 6;
    tick;
    do_start(1'b0);
    run_to_done(400);
    check("bar_done", edge_n > 0, 1);
    check("bar_wb_before_s1", wb_at_s1, 8);
    check("bar_accepts", acc_n, 32);
    check("bar_err", err, 0);
    check_seq("bar_seq");
    // spurious write-back while idle
    wb_dly = 1;
    repeat (8) tick;
    wb_man = 1'b1; tick; wb_man = 1'b0;
    tick;
    check("spur_err", err, 1);
    repeat (4) tick;
    check("spur_err_sticky", err, 1);
    do_start(1'b0);
    check("spur_err_clear", err, 0);
    run_to_done(100);
    check("spur_done", edge_n, 37);
    check("spur_accepts", acc_n, 32);
    check("spur_err_end", err, 0);
    // reset in the middle of stage 2
    tick;
    do_start(1'b0);
    for (int c = 0; c < 200 && !(bus.bf_valid && bus.bf_stage == 3'd2); c++) tick;
    check("mid_reached_s2", bus.bf_stage, 2);
    rst = 1'b1; wb_en = 1'b0; bus.bf_ready = 1'b0;
    tick;
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_valid", bus.bf_valid, 0);
    check("mid_a", bus.bf_addr_a, 0);
    check("mid_b", bus.bf_addr_b, 0);
    check("mid_tw", bus.bf_tw_idx, 0);
    check("mid_stage", bus.bf_stage, 0);
    tick;
    wb_en = 1'b1; bus.bf_ready = 1'b1;
    do_start(1'b0);
    check("restart_valid", bus.bf_valid, 1);
    check("restart_a", bus.bf_addr_a, 0);
    check("restart_b", bus.bf_addr_b, 1);
    check("restart_tw", bus.bf_tw_idx, 0);
    check("restart_stage", bus.bf_stage, 0);
    run_to_done(100);
    check("restart_done", edge_n, 37);
    check("restart_accepts", acc_n, 32);
    // inverse request
    tick;
    do_start(1'b1);
    run_to_done(100);
    check("inv_done", edge_n, 37);
    check("inv_s3_b0_tw", rt[24], 0);
`ifdef NTT_SCHED_INVERSE_EN
    check("inv_s3_b1_tw", rt[25], 15);
`else
    check("inv_s3_b1_tw", rt[25], 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
